button_decoder: RTL
===================

// Module: button_decoder
// PURPOSE
//  Input-side companion to the RGB colour-cycling FSM. It reads one raw active-low push button
//  (board pin) and synchronises and debounces it. It classifies each press as short or long and
//  emits 1-cycle command pulses (step / long / auto-repeat) that the colour FSM consumes in place
//  of its free-running blink timer. Sits between the button pin and the FSM, in the clk domain.
// PARAMETERS
//  DEBOUNCE_CYCLES    120000    consecutive stable clks needed to accept a new level (10 ms @ 12 MHz)
//  LONG_PRESS_CYCLES  12000000  debounced hold time before a press counts as long (1 s)
//  REPEAT_CYCLES      2000000   period of repeat pulses while held past long threshold
//  All parameters >= 2. Each counter width = $clog2(param+1). Counters never wrap.
// PORTS
//  clk          in   1  system clock (12 MHz)
//  rst          in   1  asynchronous, active-high reset
//  btn_n        in   1  raw button pin, active-low, asynchronous to clk, may bounce
//  pressed      out  1  debounced level, 1 = button held
//  short_press  out  1  1-cycle pulse: released before long threshold
//  long_press   out  1  1-cycle pulse: hold reached LONG_PRESS_CYCLES
//  repeat_tick  out  1  1-cycle pulse every REPEAT_CYCLES while in HELD
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync FFs and stable level = 1 (released); all counters = 0; FSM = IDLE.
//   - pressed / short_press / long_press / repeat_tick = 0. Outputs are forced low immediately on assert.
//  Synchroniser: 2-FF chain on btn_n; only the second stage is used downstream.
//  Debounce:
//   - While synced level == stable: debounce count = 0.
//   - While they differ: count increments each clk.
//   - On the edge where count == DEBOUNCE_CYCLES-1 and the levels still differ: stable <= synced, count <= 0.
//   - Any return to equality before then clears count (glitch rejected).
//   - Net: stable flips DEBOUNCE_CYCLES+2 edges after btn_n settles.
//  FSM (3 states), evaluated on the debounced press/release events:
//   IDLE:    stable press -> PRESSED; hold_cnt <= 0.
//   PRESSED: hold_cnt++ each clk.
//            Release -> IDLE and short_press pulse.
//            Else if hold_cnt == LONG_PRESS_CYCLES-1 -> HELD, long_press pulse, rep_cnt <= 0.
//            Release and threshold in the same cycle: release wins (short_press only).
//   HELD:    rep_cnt++.
//            On rep_cnt == REPEAT_CYCLES-1: repeat_tick pulse, rep_cnt <= 0.
//            Release -> IDLE with no pulse; a release coinciding with a repeat expiry suppresses that tick.
//  Outputs are all registered.
//   - pressed rises/falls 1 edge after stable flips.
//   - Each pulse is high exactly 1 clk, 1 edge after its triggering condition.
//   - At most one of short_press / long_press / repeat_tick is high in any cycle.
//   - First repeat_tick comes REPEAT_CYCLES clks after long_press.
//  Reset mid-operation:
//   - Any state returns to IDLE and in-flight pulses are dropped.
//   - A button still held at reset release is re-debounced and then treated as a fresh press.
// TESTING (bench params DEBOUNCE=4, LONG=20, REPEAT=8)
//  1. rst high 3 clks, btn_n=1 -> all outputs 0 during and after reset; no pulses for 50 clks.
//  2. btn_n low 3 clks, then high -> pressed stays 0, zero pulses (glitch rejected).
//  3. btn_n low 10 clks, then high -> pressed high ~4 clks later; exactly one short_press after
//     release; long_press never asserted.
//  4. btn_n low 60 clks -> one long_press; repeat_tick every 8 clks after it; no short_press on
//     release; pressed falls after debounce.
//  5. In HELD, pulse rst 1 clk then release -> outputs 0 asynchronously; no pulses follow.
//  6. After a 10-clk press, btn_n toggles every 2 clks for 12 clks then settles high ->
//     exactly one short_press; pressed shows a single fall.

Source files
------------

// File: rtl/button_decoder.sv
// Push-button front end: synchronises and debounces an active-low pin, then classifies
// each press into short / long / auto-repeat command pulses for the colour FSM.
module button_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES   = 120000,
   parameter int unsigned LONG_PRESS_CYCLES = 12000000,
   parameter int unsigned REPEAT_CYCLES     = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pressed,
   output logic short_press,
   output logic long_press,
   output logic repeat_tick
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic [DW-1:0] db_cnt_q;

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          short_d, long_d, tick_d;

   // Two-flop synchroniser; idles at the released level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES clks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= 1'b1;
         db_cnt_q <= '0;
      end else if (sync2_q == stable_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         stable_q <= sync2_q;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         rep_q       <= '0;
         pressed     <= 1'b0;
         short_press <= 1'b0;
         long_press  <= 1'b0;
         repeat_tick <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         rep_q       <= rep_d;
         pressed     <= ~stable_q;
         short_press <= short_d;
         long_press  <= long_d;
         repeat_tick <= tick_d;
      end
   end

   // Press classification; a release always takes priority over a same-cycle threshold
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      tick_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!stable_q) begin
               state_d = PRESSED;
               hold_d  = '0;
            end
         end
         PRESSED: begin
            if (stable_q) begin
               state_d = IDLE;
               short_d = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = HELD;
               long_d  = 1'b1;
               rep_d   = '0;
            end else begin
               hold_d  = hold_q + HW'(1);
            end
         end
         HELD: begin
            if (stable_q) begin
               state_d = IDLE;
            end else if (rep_q == REP_LAST) begin
               tick_d  = 1'b1;
               rep_d   = '0;
            end else begin
               rep_d   = rep_q + RW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
